seg7_scan_decoder: RTL and testbench
====================================

Name: seg7_scan_decoder

Overview:
- Receive side of the multiplexed 7-segment display interface.
- Samples active-low segment lines (gfedcba) and active-low digit anodes driven by a scanning display driver.
- Waits for each digit's pattern to be stable, decodes it back to its hex nibble, and presents a per-digit register bank plus a frame-complete pulse.
- Used for loopback self-test of the display path and for reading an external display bus.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (anode lines), range 1..8.
- STABLE_CYCLES, 8, consecutive identical synchronized samples required before capture, range 2..255.
- SYNC_STAGES, 2, flip-flop synchronizer depth on seg_n and an_n, range 2..3.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- seg_n  input  7  segment lines gfedcba, active-low (0 = segment lit), asynchronous to clk.
- an_n  input  NUM_DIGITS  digit select, active-low, one-hot when valid, asynchronous to clk.
- clear_err  input  1  synchronous clear of decode_err_o.
- digits_o  output  4*NUM_DIGITS  decoded nibbles; digit k is at [4k+3:4k].
- digit_valid_o  output  NUM_DIGITS  bit k = digit k holds a successfully decoded pattern.
- blank_o  output  NUM_DIGITS  bit k = last capture on digit k was all-off (7'b1111111).
- frame_valid_o  output  1  one-cycle pulse when every digit has been captured since the last pulse.
- decode_err_o  output  1  sticky flag: an unrecognised pattern was captured.

Behaviour:
- Reset (async assert, sync release): digits_o=0, digit_valid_o=0, blank_o=0, frame_valid_o=0, decode_err_o=0. Stability counter=0, seen mask=0. Synchronizer flops are reset to all-ones (idle/blank).
- Synchronizer: seg_n and an_n each pass through SYNC_STAGES flops. All further logic uses the synchronized values only.
- Stability counter (8 bit):
  - If the synchronized {an_n, seg_n} differs from the previous cycle's, or an_n is not exactly one-hot-low, the counter is loaded with 1 (with 0 when an_n is not one-hot).
  - Otherwise it increments, saturating at STABLE_CYCLES.
- Capture: occurs in the single cycle the counter transitions STABLE_CYCLES-1 -> STABLE_CYCLES. Capture is exactly once per dwell; a longer dwell does not re-capture. Outputs update on that clock edge (registered).
- Latency: input pin change to output update = SYNC_STAGES + STABLE_CYCLES clocks.
- Decode table (inverse of the team's hex encoder, gfedcba active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0011000, A=0001000, B=0000011
  - C=1000110, D=0100001, E=0000110, F=0001110
- Capture on digit k, valid pattern: digits_o[k] = nibble, digit_valid_o[k]=1, blank_o[k]=0, seen[k]=1.
- Capture, blank 1111111: digits_o[k] unchanged, blank_o[k]=1, digit_valid_o[k]=1, seen[k]=1.
- Capture, any other pattern: digits_o[k] unchanged, digit_valid_o[k]=0, blank_o[k]=0, decode_err_o=1, seen[k] unchanged.
- Frame:
  - When a capture makes seen all-ones, frame_valid_o pulses high for exactly that one cycle, aligned with the digit update, and seen clears to 0 on the same edge.
  - Re-capturing an already-seen digit does not pulse.
  - NUM_DIGITS=1: every non-error capture pulses.
- clear_err:
  - Clears decode_err_o on the next edge.
  - If an error capture occurs in the same cycle, set wins and decode_err_o stays 1.
- Zero or multiple anodes active: no capture, counter held at 0, outputs unchanged.
- Reset mid-dwell: everything returns to reset values immediately. After release, a full SYNC_STAGES + STABLE_CYCLES dwell is required before any capture.

Test Plan:
- Reset, then drive an_n=4'b1110, seg_n=7'b0100100 held 20 clocks -> digits_o[3:0]=4'h2 and digit_valid_o=4'b0001 exactly 10 clocks after the pin change; frame_valid_o stays 0; only one capture occurs.
- Scan digits 0..3 with patterns for 1, A, 7, F, dwell 12 clocks each -> digits_o=16'hF7A1; a single frame_valid_o pulse on the digit-3 update cycle; seen cleared afterwards.
- Glitch: seg_n toggles every 5 clocks on digit 0 (never 8 stable) -> no capture, outputs remain at reset values.
- Invalid pattern 7'b1010101 on digit 2 held 12 clocks -> decode_err_o=1, digit_valid_o[2]=0, digits_o[11:8] unchanged. Pulse clear_err in the same cycle as a second error capture -> decode_err_o stays 1. Pulse clear_err alone -> decode_err_o=0 next clock.
- an_n=4'b1100 (two active) with a valid pattern for 30 clocks -> no capture. Then blank 7'b1111111 on digit 1 -> blank_o[1]=1, digit_valid_o[1]=1.
- Assert rst_n low 3 clocks into a stable dwell on digit 0 -> all outputs 0 asynchronously. After release, the capture occurs only after a full 10-clock dwell.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// Receive side of a multiplexed 7-segment bus: synchronizes the segment and
// anode lines, waits for a stable dwell on one digit, decodes the pattern back
// to a hex nibble and maintains a per-digit register bank with a frame pulse.
module seg7_scan_decoder #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 8,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    input  logic                    clear_err,
    output logic [4*NUM_DIGITS-1:0] digits_o,
    output logic [NUM_DIGITS-1:0]   digit_valid_o,
    output logic [NUM_DIGITS-1:0]   blank_o,
    output logic                    frame_valid_o,
    output logic                    decode_err_o
);

    localparam int unsigned SEG_W = 7;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned ACT_W = 4;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [SEG_W-1:0]      SEG_BLANK = 7'b1111111;
    localparam logic [CNT_W-1:0]      CNT_CAP   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(STABLE_CYCLES);
    localparam logic [NUM_DIGITS-1:0] SEEN_ALL  = '1;

    logic [SEG_W-1:0]      seg_sync [SYNC_STAGES];
    logic [NUM_DIGITS-1:0] an_sync  [SYNC_STAGES];
    logic [SEG_W-1:0]      seg_s;
    logic [NUM_DIGITS-1:0] an_s;
    logic [SEG_W-1:0]      prev_seg;
    logic [NUM_DIGITS-1:0] prev_an;
    logic [CNT_W-1:0]      cnt;
    logic [NUM_DIGITS-1:0] seen;

    logic [ACT_W-1:0]      act_cnt;
    logic [IDX_W-1:0]      act_idx;
    logic [IDX_W+1:0]      nib_lsb;
    logic                  one_hot_c;
    logic                  same_c;
    logic                  capture_c;
    logic [4:0]            dec;
    logic                  dec_ok;
    logic                  is_blank;
    logic [NUM_DIGITS-1:0] seen_next;

    // Inverse of the hex encoder; bit 4 flags a recognised pattern
    function automatic logic [4:0] decode_seg(input logic [SEG_W-1:0] p);
        case (p)
            7'b1000000: return 5'h10;
            7'b1111001: return 5'h11;
            7'b0100100: return 5'h12;
            7'b0110000: return 5'h13;
            7'b0011001: return 5'h14;
            7'b0010010: return 5'h15;
            7'b0000010: return 5'h16;
            7'b1111000: return 5'h17;
            7'b0000000: return 5'h18;
            7'b0011000: return 5'h19;
            7'b0001000: return 5'h1A;
            7'b0000011: return 5'h1B;
            7'b1000110: return 5'h1C;
            7'b0100001: return 5'h1D;
            7'b0000110: return 5'h1E;
            7'b0001110: return 5'h1F;
            default:    return 5'h00;
        endcase
    endfunction

    // Synchronizer chains, reset to all-ones so an idle bus reads as no anode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                seg_sync[i] <= '1;
                an_sync[i]  <= '1;
            end
        end else begin
            seg_sync[0] <= seg_n;
            an_sync[0]  <= an_n;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                seg_sync[i] <= seg_sync[i-1];
                an_sync[i]  <= an_sync[i-1];
            end
        end
    end

    assign seg_s = seg_sync[SYNC_STAGES-1];
    assign an_s  = an_sync[SYNC_STAGES-1];

    // Active-anode count/index, stability test, capture strobe and decode
    always_comb begin
        act_cnt = '0;
        act_idx = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (!an_s[i]) begin
                act_cnt = act_cnt + ACT_W'(1);
                act_idx = IDX_W'(i);
            end
        end
        nib_lsb   = {act_idx, 2'b00};
        one_hot_c = (act_cnt == ACT_W'(1));
        same_c    = (seg_s == prev_seg) && (an_s == prev_an);
        capture_c = one_hot_c && same_c && (cnt == CNT_CAP);
        dec       = decode_seg(seg_s);
        dec_ok    = dec[4];
        is_blank  = (seg_s == SEG_BLANK);
        seen_next = seen | (NUM_DIGITS'(1) << act_idx);
    end

    // Dwell counter: restarts on any change, parks at zero without a single anode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_seg <= '1;
            prev_an  <= '1;
            cnt      <= '0;
        end else begin
            prev_seg <= seg_s;
            prev_an  <= an_s;
            if (!one_hot_c) begin
                cnt <= '0;
            end else if (!same_c) begin
                cnt <= CNT_W'(1);
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Register bank, frame tracking and sticky error, updated on the capture edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_o      <= '0;
            digit_valid_o <= '0;
            blank_o       <= '0;
            frame_valid_o <= 1'b0;
            decode_err_o  <= 1'b0;
            seen          <= '0;
        end else begin
            frame_valid_o <= 1'b0;
            if (capture_c && (dec_ok || is_blank)) begin
                if (dec_ok) begin
                    digits_o[nib_lsb +: 4] <= dec[3:0];
                    blank_o[act_idx]       <= 1'b0;
                end else begin
                    blank_o[act_idx]       <= 1'b1;
                end
                digit_valid_o[act_idx] <= 1'b1;
                if (seen_next == SEEN_ALL) begin
                    frame_valid_o <= 1'b1;
                    seen          <= '0;
                end else begin
                    seen          <= seen_next;
                end
            end else if (capture_c) begin
                digit_valid_o[act_idx] <= 1'b0;
                blank_o[act_idx]       <= 1'b0;
            end

            if (capture_c && !dec_ok && !is_blank) begin
                decode_err_o <= 1'b1;
            end else if (clear_err) begin
                decode_err_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: a run-length/lookup-table model checked every
// cycle, plus directed literal expectations scheduled against the cycle count.
module tb_seg7_scan_decoder;

    localparam int NUM_DIGITS    = 4;
    localparam int STABLE_CYCLES = 8;
    localparam int SYNC_STAGES   = 2;

    localparam logic [6:0] PAT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    localparam int K_DIGITS = 0;
    localparam int K_VALID  = 1;
    localparam int K_BLANK  = 2;
    localparam int K_FRAME  = 3;
    localparam int K_ERR    = 4;
    localparam int K_FCOUNT = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        clear_err;
    logic [15:0] digits_o;
    logic [3:0]  digit_valid_o;
    logic [3:0]  blank_o;
    logic        frame_valid_o;
    logic        decode_err_o;

    seg7_scan_decoder #(
        .NUM_DIGITS   (NUM_DIGITS),
        .STABLE_CYCLES(STABLE_CYCLES),
        .SYNC_STAGES  (SYNC_STAGES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .seg_n        (seg_n),
        .an_n         (an_n),
        .clear_err    (clear_err),
        .digits_o     (digits_o),
        .digit_valid_o(digit_valid_o),
        .blank_o      (blank_o),
        .frame_valid_o(frame_valid_o),
        .decode_err_o (decode_err_o)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int fcount     = 0;

    // Model state: outputs expected after the most recent edge
    logic [15:0] m_digits;
    logic [3:0]  m_valid, m_blank;
    logic        m_frame, m_err;
    logic [3:0]  m_seen;
    logic [10:0] pq [$];
    logic [10:0] m_prev;
    int          run;

    typedef struct {
        int          at;
        int          kind;
        logic [31:0] exp;
        string       name;
    } lit_t;
    lit_t lits [$];

    // Schedule a literal check for the negedge following the k-th posedge from now
    task automatic expect_at(input int k, input int kind, input logic [31:0] e, input string nm);
        lit_t l;
        l.at = cyc + k + 1; l.kind = kind; l.exp = e; l.name = nm;
        lits.push_back(l);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] act_of(input int kind);
        case (kind)
            K_DIGITS: return 32'(digits_o);
            K_VALID:  return 32'(digit_valid_o);
            K_BLANK:  return 32'(blank_o);
            K_FRAME:  return 32'(frame_valid_o);
            K_ERR:    return 32'(decode_err_o);
            default:  return 32'(fcount);
        endcase
    endfunction

    // Model: the sample seen at an edge is the pin value SYNC_STAGES edges old;
    // a capture happens when the STABLE_CYCLES-th identical single-anode sample arrives
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            pq = {};
            for (int i = 0; i < SYNC_STAGES; i++) pq.push_back(11'h7ff);
            m_prev = 11'h7ff; run = 0;
            m_digits = '0; m_valid = '0; m_blank = '0; m_frame = 1'b0; m_err = 1'b0; m_seen = '0;
        end else begin
            logic [10:0] s;
            int nact, idx, nib;
            logic err_cap;
            s = pq.pop_front();
            pq.push_back({an_n, seg_n});
            nact = 0; idx = 0;
            for (int i = 0; i < NUM_DIGITS; i++) if (!s[7+i]) begin nact++; idx = i; end
            if (nact != 1)      run = 0;
            else if (s != m_prev) run = 1;
            else                run = run + 1;
            m_prev  = s;
            m_frame = 1'b0;
            err_cap = 1'b0;
            if (run == STABLE_CYCLES) begin
                nib = -1;
                for (int j = 0; j < 16; j++) if (PAT[j] == s[6:0]) nib = j;
                if (nib >= 0 || s[6:0] == 7'h7f) begin
                    if (nib >= 0) begin
                        m_digits[4*idx +: 4] = 4'(nib);
                        m_blank[idx] = 1'b0;
                    end else begin
                        m_blank[idx] = 1'b1;
                    end
                    m_valid[idx] = 1'b1;
                    m_seen[idx]  = 1'b1;
                    if (m_seen == 4'hF) begin
                        m_frame = 1'b1;
                        m_seen  = '0;
                    end
                end else begin
                    m_valid[idx] = 1'b0;
                    m_blank[idx] = 1'b0;
                    err_cap = 1'b1;
                end
            end
            if (err_cap)        m_err = 1'b1;
            else if (clear_err) m_err = 1'b0;
        end
    end

    // Single compare process: model check every cycle, then any due literals
    initial forever begin
        @(negedge clk);
        cyc++;
        if (frame_valid_o === 1'b1) fcount++;
        chk("digits_o",      32'(digits_o),      32'(m_digits));
        chk("digit_valid_o", 32'(digit_valid_o), 32'(m_valid));
        chk("blank_o",       32'(blank_o),       32'(m_blank));
        chk("frame_valid_o", 32'(frame_valid_o), 32'(m_frame));
        chk("decode_err_o",  32'(decode_err_o),  32'(m_err));
        while (lits.size() > 0 && lits[0].at <= cyc) begin
            lit_t l;
            l = lits.pop_front();
            if (l.at < cyc) begin
                compared++;
                mismatched++;
                $display("FAIL %s: scheduled cycle %0d missed at %0d", l.name, l.at, cyc);
            end else begin
                chk(l.name, act_of(l.kind), l.exp);
            end
        end
    end

    initial begin
        rst_n = 1'b0; seg_n = 7'h7f; an_n = 4'hF; clear_err = 1'b0;
        step(3);
        expect_at(0, K_DIGITS, 32'h0, "reset_digits");
        expect_at(0, K_VALID,  32'h0, "reset_valid");
        expect_at(0, K_ERR,    32'h0, "reset_err");
        rst_n = 1'b1;
        step(2);

        // Glitching segments on digit 0 never dwell long enough
        an_n = 4'b1110;
        for (int i = 0; i < 8; i++) begin
            seg_n = (i % 2 == 0) ? 7'b0000000 : 7'b1000000;
            step(5);
        end
        expect_at(0, K_DIGITS, 32'h0, "glitch_digits");
        expect_at(0, K_VALID,  32'h0, "glitch_valid");

        // Single capture of '2' on digit 0 with exact latency
        seg_n = 7'b0100100;
        expect_at(9,  K_VALID,  32'h0, "lat_before");
        expect_at(10, K_VALID,  32'h1, "lat_valid");
        expect_at(10, K_DIGITS, 32'h2, "lat_digit");
        step(20);
        expect_at(0, K_FCOUNT, 32'd0, "no_frame_yet");

        // Scan 1, A, 7, F across digits 0..3
        an_n = 4'b1110; seg_n = 7'b1111001; step(12);
        an_n = 4'b1101; seg_n = 7'b0001000; step(12);
        an_n = 4'b1011; seg_n = 7'b1111000; step(12);
        an_n = 4'b0111; seg_n = 7'b0001110;
        expect_at(9,  K_FRAME,  32'h0,    "frame_early");
        expect_at(10, K_FRAME,  32'h1,    "frame_pulse");
        expect_at(10, K_DIGITS, 32'hF7A1, "scan_digits");
        expect_at(11, K_FRAME,  32'h0,    "frame_late");
        step(12);
        expect_at(0, K_FCOUNT, 32'd1, "one_frame");

        // Invalid pattern on digit 2, then error set beating clear_err
        an_n = 4'b1011; seg_n = 7'b1010101;
        expect_at(10, K_ERR,    32'h1,    "err_set");
        expect_at(10, K_VALID,  32'hB,    "err_valid");
        expect_at(10, K_DIGITS, 32'hF7A1, "err_digits");
        step(12);
        seg_n = 7'b1010100;
        step(9);
        clear_err = 1'b1;
        expect_at(1, K_ERR, 32'h1, "set_wins");
        step(1);
        clear_err = 1'b0;
        step(2);
        clear_err = 1'b1;
        expect_at(0, K_ERR, 32'h1, "err_before_clear");
        expect_at(1, K_ERR, 32'h0, "err_cleared");
        step(1);
        clear_err = 1'b0;
        step(2);

        // Two anodes active: nothing captured; then blank on digit 1
        an_n = 4'b1100; seg_n = 7'b0010010;
        step(30);
        expect_at(0, K_VALID,  32'hB,    "multi_valid");
        expect_at(0, K_DIGITS, 32'hF7A1, "multi_digits");
        an_n = 4'b1101; seg_n = 7'b1111111;
        expect_at(10, K_BLANK,  32'h2,    "blank_bit");
        expect_at(10, K_VALID,  32'hB,    "blank_valid");
        expect_at(10, K_DIGITS, 32'hF7A1, "blank_digits");
        step(12);

        // Reset three clocks into a dwell, then a full dwell after release
        an_n = 4'b1110; seg_n = 7'b0110000;
        step(3);
        rst_n = 1'b0;
        expect_at(0, K_DIGITS, 32'h0, "rst_digits");
        expect_at(0, K_VALID,  32'h0, "rst_valid");
        expect_at(0, K_BLANK,  32'h0, "rst_blank");
        step(2);
        rst_n = 1'b1;
        expect_at(9,  K_VALID,  32'h0, "post_rst_early");
        expect_at(10, K_VALID,  32'h1, "post_rst_valid");
        expect_at(10, K_DIGITS, 32'h3, "post_rst_digit");
        step(12);
        expect_at(0, K_FCOUNT, 32'd1, "frames_total");
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
